// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage for a 4-bit combinational ALU: command FIFO, registered ALU drive,
// tagged response with backpressure and sticky flags. Optional result self-check via ALU_SELFCHECK_EN.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_mismatch,
  output logic             sticky_cout,
  output logic             sticky_ovf,
  input  logic             sticky_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 12 + TAG_W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // FIFO storage and bookkeeping
  logic [EW-1:0]    fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             push, pop;
  logic [EW-1:0]    head;
  logic [3:0]       head_opcode, head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  // Issue and response registers
  logic [3:0]       alu_opcode_reg, alu_a_reg, alu_b_reg;
  logic [TAG_W-1:0] hold_tag_reg;
  logic             hold_illegal_reg;
  logic             rsp_valid_reg;
  logic [3:0]       rsp_result_reg;
  logic             rsp_cout_reg, rsp_zero_reg, rsp_overflow_reg, rsp_illegal_reg;
  logic [TAG_W-1:0] rsp_tag_reg;
  logic             rsp_hs;
  logic             capture;

  // Ready depends on registered full only, so a same-cycle pop never frees a slot early.
  assign push   = cmd_valid && !full_reg;
  assign rsp_hs = rsp_valid_reg && rsp_ready;

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_opcode = head[EW-1 -: 4];
  assign head_a      = head[EW-5 -: 4];
  assign head_b      = head[EW-9 -: 4];
  assign head_tag    = head[TAG_W-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_opcode, cmd_a, cmd_b, cmd_tag};
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_CNT);
      empty_reg <= (count_next == '0);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!empty_reg) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP: begin
        if (rsp_hs) state_next = empty_reg ? IDLE : ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    case (state_reg)
      IDLE:    pop = !empty_reg;
      ISSUE:   capture = 1'b1;
      RESP:    pop = rsp_hs && !empty_reg;
      default: begin
        pop     = 1'b0;
        capture = 1'b0;
      end
    endcase
  end

  // Issue registers only change on pop, so the ALU sees its last command otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode_reg   <= '0;
      alu_a_reg        <= '0;
      alu_b_reg        <= '0;
      hold_tag_reg     <= '0;
      hold_illegal_reg <= 1'b0;
    end else if (pop) begin
      alu_opcode_reg   <= head_opcode;
      alu_a_reg        <= head_a;
      alu_b_reg        <= head_b;
      hold_tag_reg     <= head_tag;
      hold_illegal_reg <= (head_opcode > 4'd4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg    <= 1'b0;
      rsp_result_reg   <= '0;
      rsp_cout_reg     <= 1'b0;
      rsp_zero_reg     <= 1'b0;
      rsp_overflow_reg <= 1'b0;
      rsp_illegal_reg  <= 1'b0;
      rsp_tag_reg      <= '0;
    end else if (capture) begin
      rsp_valid_reg    <= 1'b1;
      rsp_result_reg   <= alu_result;
      rsp_cout_reg     <= alu_cout;
      rsp_zero_reg     <= alu_zero;
      rsp_overflow_reg <= alu_overflow;
      rsp_illegal_reg  <= hold_illegal_reg;
      rsp_tag_reg      <= hold_tag_reg;
    end else if (rsp_hs) begin
      rsp_valid_reg <= 1'b0;
    end
  end

`ifdef ALU_SELFCHECK_EN
  logic [3:0] model_result;
  logic       model_mismatch;
  logic       rsp_mismatch_reg;

  always_comb begin
    model_result = 4'd0;
    case (alu_opcode_reg)
      4'd0:    model_result = alu_a_reg + alu_b_reg;
      4'd1:    model_result = alu_a_reg - alu_b_reg;
      4'd2:    model_result = alu_a_reg & alu_b_reg;
      4'd3:    model_result = alu_a_reg | alu_b_reg;
      4'd4:    model_result = alu_a_reg ^ alu_b_reg;
      default: model_result = 4'd0;
    endcase
  end

  // Carry and overflow conventions belong to the ALU, so only result and zero are judged.
  assign model_mismatch = (model_result != alu_result) ||
                          ((model_result == 4'd0) != alu_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rsp_mismatch_reg <= 1'b0;
    else if (capture) rsp_mismatch_reg <= model_mismatch;
  end

  assign rsp_mismatch = rsp_mismatch_reg;
`else
  assign rsp_mismatch = 1'b0;
`endif

  // Sticky bit 0 tracks carry, bit 1 overflow; a setting handshake beats a clear.
  logic [1:0] sticky_flag;
  logic [1:0] sticky_bits;

  assign sticky_flag = {rsp_overflow_reg, rsp_cout_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sticky
      logic bit_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bit_reg <= 1'b0;
        end else if (sticky_clr || rsp_hs) begin
          bit_reg <= (sticky_clr ? 1'b0 : bit_reg) | (rsp_hs & sticky_flag[gi]);
        end
      end
      assign sticky_bits[gi] = bit_reg;
    end
  endgenerate

  assign cmd_ready    = !full_reg;
  assign alu_opcode   = alu_opcode_reg;
  assign alu_a        = alu_a_reg;
  assign alu_b        = alu_b_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_result   = rsp_result_reg;
  assign rsp_cout     = rsp_cout_reg;
  assign rsp_zero     = rsp_zero_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign rsp_illegal  = rsp_illegal_reg;
  assign rsp_tag      = rsp_tag_reg;
  assign sticky_cout  = sticky_bits[0];
  assign sticky_ovf   = sticky_bits[1];

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Upstream issue/capture stage for the 4-bit combinational ALU.
- Accepts tagged ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Drives registered opcode/operands into the ALU, captures the ALU result and flags one cycle later, and presents them as a tagged response with valid/ready backpressure.
- Maintains sticky status flags for software polling.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, minimum 2
TAG_W, 4, width of the command tag carried through to the response

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !full
cmd_opcode  input  4  0=ADD 1=SUB 2=AND 3=OR 4=XOR; others illegal
cmd_a  input  4  operand A
cmd_b  input  4  operand B
cmd_tag  input  TAG_W  opaque tag
alu_opcode  output  4  registered opcode to ALU
alu_a  output  4  registered operand A to ALU
alu_b  output  4  registered operand B to ALU
alu_result  input  4  ALU result
alu_cout  input  1  ALU carry-out
alu_zero  input  1  ALU zero flag
alu_overflow  input  1  ALU overflow flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  4  captured result
rsp_cout  output  1  captured carry
rsp_zero  output  1  captured zero
rsp_overflow  output  1  captured overflow
rsp_illegal  output  1  command opcode was > 4
rsp_tag  output  TAG_W  tag of the command
rsp_mismatch  output  1  self-check failure (see Optional Feature)
sticky_cout  output  1  OR of all responded couts since clear
sticky_ovf  output  1  OR of all responded overflows since clear
sticky_clr  input  1  synchronous clear of sticky flags

Behaviour:
- Reset (async, rst=1): FIFO empty, FSM=IDLE, and every output 0, with one exception: cmd_ready=1 once the FIFO is empty. All in-flight and buffered commands are dropped. Reset mid-operation gives no partial response.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready is derived from registered full only, so there is no push when full even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full is legal; the count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, RESP:
  - IDLE: if FIFO non-empty, pop head into alu_opcode/alu_a/alu_b and the holding tag/illegal registers, then go to ISSUE. Otherwise stay.
  - ISSUE: ALU inputs are stable. At the end of the cycle, capture alu_result/cout/zero/overflow into the rsp_* registers, set rsp_valid=1, and go to RESP.
  - RESP: all rsp_* are held stable while rsp_valid&&!rsp_ready. On handshake, rsp_valid drops next cycle. If the FIFO is non-empty at handshake, pop in the same cycle and go directly to ISSUE; else go to IDLE.
- alu_* outputs hold their last issued values outside ISSUE.
- Latency: command accepted in cycle 0 -> rsp_valid high in cycle 3 (FIFO empty, rsp_ready=1). Sustained throughput is 1 response per 2 cycles.
- Illegal opcode (5..15): issued to the ALU unchanged. The ALU's response is captured as-is and rsp_illegal=1.
- Sticky flags: updated on response handshake. If sticky_clr and a setting handshake occur in the same cycle, set wins.
- No arithmetic is performed in this block; ALU outputs are captured bit-exact.

Optional Feature:
ALU_SELFCHECK_EN
- Defined:
  - An internal model computes the expected 4-bit result from alu_opcode/alu_a/alu_b: a+b, a-b (mod 16), &, |, ^, else 0.
  - In ISSUE the model is compared against alu_result and alu_zero; the carry and overflow flags are not compared.
  - A disagreement sets rsp_mismatch=1 with that response.
- Undefined: rsp_mismatch is tied 0 and no model logic exists.

Test Plan:
- ADD a=7 b=1 tag=3, rsp_ready=1 -> rsp_valid in cycle 3, rsp_result=8, rsp_overflow=1, rsp_zero=0, rsp_tag=3, rsp_illegal=0.
- SUB a=5 b=5 -> rsp_result=0, rsp_zero=1, rsp_overflow=0.
- Opcode 9, a=F b=F -> rsp_result=0, rsp_zero=1, rsp_illegal=1.
- rsp_ready=0, DEPTH=4, cmd_valid continuous -> exactly 5 accepted, then cmd_ready=0. Releasing rsp_ready returns the responses in order with tags 0..4, fields stable while stalled.
- Assert rst in ISSUE with 3 commands queued -> rsp_valid=0 immediately, cmd_ready=1, no responses emitted after release.
- Overflow response handshake in the same cycle as sticky_clr=1 -> sticky_ovf=1 afterwards. sticky_clr alone next cycle -> sticky_ovf=0.
